// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared opcodes and default widths for the ALU issue stage
package alu_issue_pkg;
   localparam int DW_DEF = 32;
   localparam int AW_DEF = 5;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SRL = 3'b100;
   localparam logic [2:0] OP_SRA = 3'b101;
endpackage

// File: rtl/alu_issue_grf.sv
// rtl/alu_issue_grf.sv - general register file: two async read ports, debug read, one sync write
module alu_issue_grf
   import alu_issue_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] ra_addr,
   output logic [DW-1:0] ra_data,
   input  logic [AW-1:0] rb_addr,
   output logic [DW-1:0] rb_data,
   input  logic [AW-1:0] dbg_addr,
   output logic [DW-1:0] dbg_data,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata
);
   localparam int NREG = 1 << AW;

   logic [DW-1:0] regs_q [NREG];
   logic [DW-1:0] regs_d [NREG];

   // Entry 0 is forced to zero so it never holds a written value.
   always_comb begin
      regs_d = regs_q;
      if (we && (waddr != '0)) regs_d[waddr] = wdata;
      regs_d[0] = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   assign ra_data  = regs_q[ra_addr];
   assign rb_data  = regs_q[rb_addr];
   assign dbg_data = regs_q[dbg_addr];
endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ISSUE/EX feeder for the 32-bit ALU; ALU_ISSUE_FORWARD_EN selects forwarding over stalling
module alu_issue_stage
   import alu_issue_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    in_op,
   input  logic [AW-1:0] in_rs,
   input  logic [AW-1:0] in_rt,
   input  logic [AW-1:0] in_rd,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [2:0]    alu_op,
   input  logic [DW-1:0] alu_c,
   output logic          wb_valid,
   output logic [AW-1:0] wb_rd,
   output logic [DW-1:0] wb_data,
   output logic [31:0]   retire_cnt,
   input  logic [AW-1:0] dbg_addr,
   output logic [DW-1:0] dbg_data
);
   logic          ex_valid_q, ex_valid_d;
   logic [DW-1:0] alu_a_q, alu_a_d;
   logic [DW-1:0] alu_b_q, alu_b_d;
   logic [2:0]    alu_op_q, alu_op_d;
   logic [AW-1:0] wb_rd_q, wb_rd_d;
   logic [31:0]   retire_cnt_q, retire_cnt_d;

   logic [DW-1:0] grf_a, grf_b, op_a, op_b;
   logic          hit_rs, hit_rt, accept;

   alu_issue_grf #(.DW(DW), .AW(AW)) u_grf (
      .clk      (clk),
      .rst_n    (rst_n),
      .ra_addr  (in_rs),
      .ra_data  (grf_a),
      .rb_addr  (in_rt),
      .rb_data  (grf_b),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .we       (ex_valid_q),
      .waddr    (wb_rd_q),
      .wdata    (alu_c)
   );

   // An operand collides with the EX write only for a nonzero destination.
   assign hit_rs = ex_valid_q && (wb_rd_q != '0) && (in_rs == wb_rd_q);
   assign hit_rt = ex_valid_q && (wb_rd_q != '0) && (in_rt == wb_rd_q);

`ifdef ALU_ISSUE_FORWARD_EN
   assign in_ready = 1'b1;
   assign op_a     = hit_rs ? alu_c : grf_a;
   assign op_b     = hit_rt ? alu_c : grf_b;
`else
   assign in_ready = !(hit_rs || hit_rt);
   assign op_a     = grf_a;
   assign op_b     = grf_b;
`endif

   assign accept = in_valid && in_ready;

   always_comb begin
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      wb_rd_d      = wb_rd_q;
      ex_valid_d   = accept;
      retire_cnt_d = retire_cnt_q + 32'(ex_valid_q);
      if (accept) begin
         alu_a_d  = op_a;
         alu_b_d  = op_b;
         alu_op_d = in_op;
         wb_rd_d  = in_rd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q   <= 1'b0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= OP_ADD;
         wb_rd_q      <= '0;
         retire_cnt_q <= '0;
      end else begin
         ex_valid_q   <= ex_valid_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         wb_rd_q      <= wb_rd_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_op     = alu_op_q;
   assign wb_valid   = ex_valid_q;
   assign wb_rd      = wb_rd_q;
   assign wb_data    = alu_c;
   assign retire_cnt = retire_cnt_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - table-driven scoreboard bench for alu_issue_stage with a reference ALU
module tb_alu_issue_stage;
   import alu_issue_pkg::*;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [2:0]    in_op = 3'b000;
   logic [AW-1:0] in_rs = '0, in_rt = '0, in_rd = '0, dbg_addr = '0;
   logic [DW-1:0] alu_a, alu_b, alu_c, wb_data, dbg_data;
   logic [2:0]    alu_op;
   logic          wb_valid;
   logic [AW-1:0] wb_rd;
   logic [31:0]   retire_cnt;

   // Seeding: an accepted instruction can carry a forced ALU result for its EX cycle.
   logic          seed_req = 1'b0;
   logic [DW-1:0] seed_val_req = '0;
   logic          seed_ex;
   logic [DW-1:0] seed_val_ex;

   always #5 clk = ~clk;

   alu_issue_stage #(.DW(DW), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_rs      (in_rs),
      .in_rt      (in_rt),
      .in_rd      (in_rd),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_c      (alu_c),
      .wb_valid   (wb_valid),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .retire_cnt (retire_cnt),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
   );

   function automatic logic [DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
      case (op)
         3'b000:  return a + b;
         3'b001:  return a - b;
         3'b010:  return a & b;
         3'b011:  return a | b;
         3'b100:  return a >> b[4:0];
         default: return $unsigned($signed(a) >>> b[4:0]);
      endcase
   endfunction

   always_comb alu_c = seed_ex ? seed_val_ex : ref_alu(alu_op, alu_a, alu_b);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seed_ex     <= 1'b0;
         seed_val_ex <= '0;
      end else begin
         seed_ex     <= in_valid && in_ready && seed_req;
         seed_val_ex <= seed_val_req;
      end
   end

   typedef struct {
      logic [2:0]    op;
      logic [AW-1:0] rs, rt, rd;
      bit            seed;
      logic [DW-1:0] sval;
      bit            dep;
      bit            chk_ab;
      logic [DW-1:0] ea, eb;
      bit            chk_dbg;
      logic [AW-1:0] daddr;
      logic [DW-1:0] dexp;
   } vec_t;

   typedef struct {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } sb_t;

   vec_t          vecs[$];
   sb_t           sbq[$];
   sb_t           sb_e;
   logic [DW-1:0] model_grf [32];
   int            checks = 0;
   int            failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] op, input int rs, input int rt, input int rd,
                               input bit seed, input logic [DW-1:0] sval, input bit dep,
                               input bit chk_ab, input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                               input bit chk_dbg, input int daddr, input logic [DW-1:0] dexp);
      vec_t v;
      v.op = op; v.rs = AW'(rs); v.rt = AW'(rt); v.rd = AW'(rd);
      v.seed = seed; v.sval = sval; v.dep = dep;
      v.chk_ab = chk_ab; v.ea = ea; v.eb = eb;
      v.chk_dbg = chk_dbg; v.daddr = AW'(daddr); v.dexp = dexp;
      return v;
   endfunction

   task automatic issue(input vec_t v, input int idx);
      int            stalls;
      int            exp_stalls;
      logic [DW-1:0] a, b, r;
      stalls = 0;
`ifdef ALU_ISSUE_FORWARD_EN
      exp_stalls = 0;
`else
      exp_stalls = v.dep ? 1 : 0;
`endif
      @(negedge clk);
      in_op = v.op; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd;
      seed_req = v.seed; seed_val_req = v.sval;
      in_valid = 1'b1;
      #1;
      while (!in_ready && stalls < 20) begin
         stalls++;
         @(negedge clk);
         #1;
      end
      chk($sformatf("stall_cycles[%0d]", idx), 32'(stalls), 32'(exp_stalls));
      if (!in_ready) begin
         in_valid = 1'b0;
         seed_req = 1'b0;
         return;
      end
      @(posedge clk);
      a = model_grf[v.rs];
      b = model_grf[v.rt];
      r = v.seed ? v.sval : ref_alu(v.op, a, b);
      sbq.push_back('{rd: v.rd, data: r});
      if (v.rd != '0) model_grf[v.rd] = r;
      #1;
      in_valid = 1'b0;
      seed_req = 1'b0;
      if (v.chk_ab) begin
         chk($sformatf("alu_a[%0d]", idx), alu_a, v.ea);
         chk($sformatf("alu_b[%0d]", idx), alu_b, v.eb);
         chk($sformatf("alu_op[%0d]", idx), 32'(alu_op), 32'(v.op));
      end
      if (v.chk_dbg) begin
         dbg_addr = v.daddr;
         #1;
         chk($sformatf("grf_r%0d[%0d]", v.daddr, idx), dbg_data, v.dexp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && wb_valid) begin
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL wb_unexpected actual=rd%0d required=no_writeback", wb_rd);
         end else begin
            sb_e = sbq.pop_front();
            chk("wb_rd", 32'(wb_rd), 32'(sb_e.rd));
            chk("wb_data", wb_data, sb_e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) model_grf[i] = '0;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_retire_cnt", retire_cnt, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_op", 32'(alu_op), 32'd0);
      chk("rst_wb_rd", 32'(wb_rd), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         dbg_addr = AW'(i);
         #0.1;
         chk($sformatf("rst_grf_r%0d", i), dbg_data, 32'd0);
      end

      //           op      rs rt rd seed sval          dep chkab ea            eb        chkdbg addr exp
      vecs.push_back(mk(OP_ADD, 0, 0, 1, 1, 32'd7,        0, 0, 0,            0,        0, 0,  0));
      vecs.push_back(mk(OP_ADD, 0, 0, 2, 1, 32'd5,        0, 0, 0,            0,        0, 0,  0));
      vecs.push_back(mk(OP_ADD, 1, 2, 3, 0, 0,            1, 1, 32'd7,        32'd5,    0, 0,  0));
      vecs.push_back(mk(OP_OR,  1, 0, 9, 0, 0,            0, 0, 0,            0,        1, 3,  32'd12));
      vecs.push_back(mk(OP_SUB, 3, 1, 4, 0, 0,            0, 1, 32'd12,       32'd7,    0, 0,  0));
      vecs.push_back(mk(OP_OR,  4, 4, 5, 0, 0,            1, 1, 32'd5,        32'd5,    0, 0,  0));
      vecs.push_back(mk(OP_ADD, 1, 2, 0, 0, 0,            0, 0, 0,            0,        0, 0,  0));
      vecs.push_back(mk(OP_ADD, 0, 0, 10, 0, 0,           0, 1, 32'd0,        32'd0,    1, 0,  32'd0));
      vecs.push_back(mk(OP_ADD, 0, 0, 6, 1, 32'h8000_0000, 0, 0, 0,           0,        0, 0,  0));
      vecs.push_back(mk(OP_ADD, 0, 0, 7, 1, 32'd4,        0, 0, 0,            0,        0, 0,  0));
      vecs.push_back(mk(OP_SRA, 6, 7, 11, 0, 0,           1, 1, 32'h8000_0000, 32'd4,   0, 0,  0));
      vecs.push_back(mk(OP_OR,  0, 0, 12, 0, 0,           0, 0, 0,            0,        1, 11, 32'hF800_0000));

      foreach (vecs[i]) issue(vecs[i], i);

      repeat (3) @(negedge clk);
      chk("retire_cnt_after_table", retire_cnt, 32'd12);
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
      dbg_addr = 5'd4;  #1; chk("final_r4", dbg_data, 32'd5);
      dbg_addr = 5'd5;  #1; chk("final_r5", dbg_data, 32'd5);
      dbg_addr = 5'd0;  #1; chk("final_r0", dbg_data, 32'd0);
      dbg_addr = 5'd11; #1; chk("final_r11", dbg_data, 32'hF800_0000);

      issue(mk(OP_ADD, 0, 0, 13, 1, 32'd99, 0, 0, 0, 0, 0, 0, 0), 100);
      chk("midrst_wb_valid_before", 32'(wb_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_wb_valid_after", 32'(wb_valid), 32'd0);
      chk("midrst_retire_cnt", retire_cnt, 32'd0);
      sbq.delete();
      @(posedge clk);
      #1;
      dbg_addr = 5'd13;
      #1;
      chk("midrst_r13", dbg_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Upstream feeder for the combinational 32-bit ALU: owns the general register file (GRF), accepts register-register ALU instructions over a valid/ready handshake, and reads operands.
- Drives registered A/B/ALUOp to the ALU, samples the ALU result C and writes it back to the destination register.
- Two-stage pipeline: ISSUE (accept and read GRF) -> EX (ALU evaluates, write-back at the end of the cycle).

Parameters:
- DW, 32, data width; must match the ALU width.
- AW, 5, register address width; the GRF has 2**AW entries.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted when in_valid && in_ready
- in_op  in  3  ALU opcode, passed through unchanged (000 add, 001 sub, 010 and, 011 or, 100 srl, others sra)
- in_rs  in  AW  source register for operand A
- in_rt  in  AW  source register for operand B
- in_rd  in  AW  destination register
- alu_a  out  DW  registered operand A to the ALU
- alu_b  out  DW  registered operand B to the ALU
- alu_op  out  3  registered opcode to the ALU
- alu_c  in  DW  ALU result, combinational from alu_a/alu_b/alu_op
- wb_valid  out  1  high during the EX cycle whose result is written at the next edge
- wb_rd  out  AW  destination of the EX-stage instruction
- wb_data  out  DW  equals alu_c while wb_valid is high
- retire_cnt  out  32  count of written-back instructions; wraps modulo 2^32
- dbg_addr  in  AW  debug read address
- dbg_data  out  DW  combinational GRF[dbg_addr]

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - All GRF entries clear to 0.
  - alu_a, alu_b, alu_op, wb_rd, retire_cnt clear to 0; wb_valid clears to 0.
- Register 0 always reads 0; writes to rd=0 are discarded, but wb_valid still pulses and retire_cnt still increments.
- ISSUE:
  - On an accept edge, alu_a <= GRF[in_rs], alu_b <= GRF[in_rt], alu_op <= in_op, wb_rd <= in_rd, ex_valid <= 1.
  - With no accept, ex_valid <= 0 and alu_a/alu_b/alu_op/wb_rd hold their values.
  - wb_valid = ex_valid.
- EX:
  - While ex_valid is high, on the clock edge GRF[wb_rd] <= alu_c (unless wb_rd = 0) and retire_cnt increments.
  - Latency: accepted in cycle N -> wb_valid in N+1 -> value readable from the GRF (dbg_data, ISSUE reads) in N+2.
- Hazard: the instruction in ISSUE names a nonzero register equal to wb_rd while ex_valid is high (rs or rt).
  - in_ready = !hazard. It may depend combinationally on in_rs/in_rt; upstream must not use in_ready to gate in_valid.
  - A stalled instruction is accepted the next cycle and reads the written value; throughput is 1 instruction per 2 cycles for back-to-back dependencies.
- No hazard: in_ready = 1 every cycle, sustaining 1 instruction per cycle.
- Same register as both rs and rt: both operands get the same value.
- in_valid low: in_ready reflects the hazard computation only and has no effect.
- Reset asserted mid-operation: the EX instruction is dropped with no write, and wb_valid falls immediately.

Optional Feature:
- Macro ALU_ISSUE_FORWARD_EN.
- Defined:
  - A hazard never stalls; in_ready = 1 constantly.
  - A matching operand takes alu_c (the EX result) instead of the GRF.
  - Dependent back-to-back throughput is 1 per cycle.
- Undefined: the stall behaviour above.

Decomposition:
- Shared package holds:
  - ALU opcode constants (OP_ADD=3'b000 … OP_SRA=3'b101).
  - DW and AW defaults.
- One sub-module, alu_issue_grf:
  - Two async read ports plus the debug read port.
  - One sync write port.
  - Async active-low reset; r0 hardwired to 0.
- The hazard/forward mux and pipeline registers stay in the top.

Test Plan:
- Reset then dbg sweep: every dbg_data = 0, wb_valid = 0, retire_cnt = 0.
- Seed r1=7 and r2=5 via writes to zero-sourced ops (or 0), then issue add r3,r1,r2 followed by an independent op:
  - alu_a=7, alu_b=5 in N+1.
  - wb_data=12.
  - GRF[3]=12 in N+2.
- Back-to-back dependency sub r4,r3,r1 then or r5,r4,r4:
  - Without the macro, in_ready=0 for one cycle; with it, no stall.
  - r4=5 and r5=5 in both builds.
  - retire_cnt correct in both builds.
- add r0,r1,r2: wb_valid pulses and retire_cnt increments, but GRF[0] stays 0; a later read of r0 yields 0 with no stall.
- sra with r6=32'h8000_0000 and r7=4: alu_op=101 and wb_data=32'hF800_0000 written to rd.
- Assert rst_n low while wb_valid=1: the target register stays 0, wb_valid drops asynchronously, and retire_cnt=0.
